// File: rtl/rs_latch_sequencer.sv
// rs_latch_sequencer: shares one asynchronous RS latch between NREQ
// requesters. Level set/clear requests become clocked, non-overlapping
// set/reset pulses. Each pulse is followed by a settle window and then a
// check of the latch feedback. A power-up clear sequence forces the latch
// into a known state before any request is granted.
module rs_latch_sequencer #(
    parameter int NREQ     = 4,
    parameter int PULSE_W  = 2,
    parameter int SETTLE_W = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] set_req,
    input  logic [NREQ-1:0] clr_req,
    input  logic            q,
    input  logic            q_bar,
    output logic            latch_set,
    output logic            latch_reset,
    output logic [NREQ-1:0] ack,
    output logic            busy,
    output logic            fault
);

    localparam int MAX_W = (PULSE_W > SETTLE_W) ? PULSE_W : SETTLE_W;
    localparam int CW    = $clog2(MAX_W + 1);
    localparam int PW    = $clog2(NREQ);

    localparam logic [CW-1:0] PULSE_LOAD  = CW'(PULSE_W - 1);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_W - 1);

    typedef enum logic [2:0] {
        RST, INIT_P, INIT_S, INIT_C, IDLE, PULSE, SETTLE, CHECK
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic            cnt_done;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   gnt;
    logic            op_clr;

    logic            found;
    logic [PW-1:0]   sel;
    logic            sel_clr;

    logic            op_nxt;
    logic [PW-1:0]   gnt_nxt;
    logic            set_nxt;
    logic            reset_nxt;
    logic [NREQ-1:0] ack_nxt;
    logic            busy_nxt;
    logic            fault_nxt;

    // Index base+k wrapped modulo NREQ (k is always below NREQ).
    function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return PW'(s);
    endfunction

    // True when the feedback pair does not show the expected q value,
    // which also covers the illegal q == q_bar case.
    function automatic logic check_mismatch(input logic exp_q, input logic fq, input logic fqb);
        return (fq != exp_q) || (fqb == exp_q);
    endfunction

    assign cnt_done = (cnt == '0);

    // Round-robin search for the first active requester starting at ptr.
    always_comb begin
        found   = 1'b0;
        sel     = ptr;
        sel_clr = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && (set_req[wrap_idx(ptr, k)] || clr_req[wrap_idx(ptr, k)])) begin
                found   = 1'b1;
                sel     = wrap_idx(ptr, k);
                sel_clr = clr_req[wrap_idx(ptr, k)];
            end
        end
    end

    // State register and the per-state dwell counter, reloaded on every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RST;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                case (state_nxt)
                    INIT_P, PULSE:  cnt <= PULSE_LOAD;
                    INIT_S, SETTLE: cnt <= SETTLE_LOAD;
                    default:        cnt <= '0;
                endcase
            end else if (!cnt_done) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            RST:     state_nxt = INIT_P;
            INIT_P:  if (cnt_done) state_nxt = INIT_S;
            INIT_S:  if (cnt_done) state_nxt = INIT_C;
            INIT_C:  state_nxt = IDLE;
            IDLE:    if (found) state_nxt = PULSE;
            PULSE:   if (cnt_done) state_nxt = SETTLE;
            SETTLE:  if (cnt_done) state_nxt = CHECK;
            CHECK:   state_nxt = IDLE;
            default: state_nxt = RST;
        endcase
    end

    // Capture the granted index and op; later request changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr    <= '0;
            gnt    <= '0;
            op_clr <= 1'b0;
        end else if (state == IDLE && found) begin
            ptr    <= wrap_idx(sel, 1);
            gnt    <= sel;
            op_clr <= sel_clr;
        end
    end

    // Output decode from the upcoming state so registered outputs line up
    // with the state they belong to. Set and reset are mutually exclusive.
    always_comb begin
        op_nxt    = (state == IDLE) ? sel_clr : op_clr;
        gnt_nxt   = (state == IDLE) ? sel : gnt;
        set_nxt   = (state_nxt == PULSE) && !op_nxt;
        reset_nxt = (state_nxt == INIT_P) || ((state_nxt == PULSE) && op_nxt);
        ack_nxt   = '0;
        if (state_nxt == CHECK) ack_nxt[gnt_nxt] = 1'b1;
        busy_nxt  = (state_nxt != IDLE);
        fault_nxt = fault;
        if (state_nxt == INIT_C && check_mismatch(1'b0, q, q_bar)) fault_nxt = 1'b1;
        if (state_nxt == CHECK && check_mismatch(!op_nxt, q, q_bar)) fault_nxt = 1'b1;
    end

    // Output registers; reset drops the latch drive and ack immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            latch_set   <= 1'b0;
            latch_reset <= 1'b0;
            ack         <= '0;
            busy        <= 1'b0;
            fault       <= 1'b0;
        end else begin
            latch_set   <= set_nxt;
            latch_reset <= reset_nxt;
            ack         <= ack_nxt;
            busy        <= busy_nxt;
            fault       <= fault_nxt;
        end
    end

endmodule

// File: tb/tb_rs_latch_sequencer.sv
// Directed bench for rs_latch_sequencer with a behavioural RS latch model.
module tb_rs_latch_sequencer;

    logic       clk;
    logic       rst_n;
    logic [3:0] set_req;
    logic [3:0] clr_req;
    logic       q;
    logic       q_bar;
    logic       latch_set;
    logic       latch_reset;
    logic [3:0] ack;
    logic       busy;
    logic       fault;

    int n_checks = 0;
    int n_fail   = 0;

    // Latch model: set wins only when asserted alone; stuck forces q low.
    logic mq    = 1'b1;
    logic stuck = 1'b0;
    always @(latch_set or latch_reset) begin
        if (latch_set && !latch_reset) mq = 1'b1;
        else if (latch_reset && !latch_set) mq = 1'b0;
    end
    assign q     = stuck ? 1'b0 : mq;
    assign q_bar = ~q;

    rs_latch_sequencer #(.NREQ(4), .PULSE_W(2), .SETTLE_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .set_req(set_req), .clr_req(clr_req),
        .q(q), .q_bar(q_bar), .latch_set(latch_set), .latch_reset(latch_reset),
        .ack(ack), .busy(busy), .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Forbidden set=reset=1 must never be driven.
    always @(negedge clk) begin
        n_checks++;
        if (latch_set && latch_reset) begin
            n_fail++;
            $display("FAIL overlap: latch_set=%b latch_reset=%b, required not both 1", latch_set, latch_reset);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic wait_ack(output logic [3:0] a, output int cyc, output logic saw_s, output logic saw_r);
        a = '0; cyc = 0; saw_s = 1'b0; saw_r = 1'b0;
        for (int i = 0; i < 20 && a == 4'b0; i++) begin
            @(negedge clk);
            cyc++;
            saw_s = saw_s | latch_set;
            saw_r = saw_r | latch_reset;
            a = ack;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; set_req = '0; clr_req = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || q !== 1'b0) begin
            n_fail++;
            $display("FAIL do_reset: busy=%b q=%b, required busy=0 q=0", busy, q);
        end
    endtask

    task automatic test_reset();
        logic [6:1] exp_r;
        logic [6:1] exp_b;
        exp_r = 6'b000011;
        exp_b = 6'b011111;
        rst_n = 1'b0; set_req = '0; clr_req = '0;
        #12;
        n_checks++;
        if ({latch_set, latch_reset, ack, busy, fault} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: set=%b reset=%b ack=%b busy=%b fault=%b, required all 0",
                     latch_set, latch_reset, ack, busy, fault);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            n_checks++;
            if (latch_reset !== exp_r[c] || latch_set !== 1'b0 || ack !== 4'b0) begin
                n_fail++;
                $display("FAIL init_drive c%0d: reset=%b set=%b ack=%b, required reset=%b set=0 ack=0",
                         c, latch_reset, latch_set, ack, exp_r[c]);
            end
            n_checks++;
            if (busy !== exp_b[c] || fault !== 1'b0) begin
                n_fail++;
                $display("FAIL init_busy c%0d: busy=%b fault=%b, required busy=%b fault=0", c, busy, fault, exp_b[c]);
            end
        end
        n_checks++;
        if (q !== 1'b0) begin
            n_fail++;
            $display("FAIL init_q: q=%b, required 0", q);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_set();
        logic [6:0] exp_s;
        logic [6:0] exp_b;
        exp_s = 7'b0000110;
        exp_b = 7'b0111110;
        set_req = 4'b0010;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            n_checks++;
            if (latch_set !== exp_s[c] || latch_reset !== 1'b0 || busy !== exp_b[c]) begin
                n_fail++;
                $display("FAIL single_set c%0d: set=%b reset=%b busy=%b, required set=%b reset=0 busy=%b",
                         c, latch_set, latch_reset, busy, exp_s[c], exp_b[c]);
            end
            n_checks++;
            if (ack !== ((c == 5) ? 4'b0010 : 4'b0000) || fault !== 1'b0) begin
                n_fail++;
                $display("FAIL single_ack c%0d: ack=%b fault=%b, required ack=%b fault=0",
                         c, ack, fault, (c == 5) ? 4'b0010 : 4'b0000);
            end
            if (c == 5) begin
                @(posedge clk); #1;
                set_req = '0;
            end
        end
        n_checks++;
        if (q !== 1'b1) begin
            n_fail++;
            $display("FAIL single_q: q=%b, required 1", q);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        logic [3:0] a;
        int cyc;
        logic ss, sr;
        logic [3:0] exp_a;
        do_reset();
        set_req = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            if (k == 4) set_req = 4'b0101;
            exp_a = (k < 4) ? 4'(1 << k) : ((k == 4) ? 4'b0001 : 4'b0100);
            wait_ack(a, cyc, ss, sr);
            n_checks++;
            if (a !== exp_a || cyc != 6) begin
                n_fail++;
                $display("FAIL rr_order k%0d: ack=%b after %0d cycles, required ack=%b after 6", k, a, cyc, exp_a);
            end
            n_checks++;
            if (ss !== 1'b1 || sr !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_pulse k%0d: saw_set=%b saw_reset=%b, required 1 0", k, ss, sr);
            end
            @(posedge clk); #1;
            set_req = set_req & ~exp_a;
        end
    endtask

    task automatic test_clear_priority();
        logic [3:0] a;
        int cyc;
        logic ss, sr;
        set_req = 4'b0100; clr_req = 4'b0100;
        wait_ack(a, cyc, ss, sr);
        n_checks++;
        if (a !== 4'b0100 || ss !== 1'b0 || sr !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_prio: ack=%b saw_set=%b saw_reset=%b, required ack=0100 0 1", a, ss, sr);
        end
        n_checks++;
        if (q !== 1'b0 || fault !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_prio_q: q=%b fault=%b, required q=0 fault=0", q, fault);
        end
        @(posedge clk); #1;
        set_req = '0; clr_req = '0;
    endtask

    task automatic test_fault();
        logic [3:0] a;
        int cyc;
        logic ss, sr;
        stuck = 1'b1;
        set_req = 4'b0001;
        wait_ack(a, cyc, ss, sr);
        n_checks++;
        if (a !== 4'b0001 || fault !== 1'b1) begin
            n_fail++;
            $display("FAIL fault_set: ack=%b fault=%b, required ack=0001 fault=1", a, fault);
        end
        @(posedge clk); #1;
        set_req = '0; stuck = 1'b0;
        clr_req = 4'b0010;
        wait_ack(a, cyc, ss, sr);
        n_checks++;
        if (a !== 4'b0010 || fault !== 1'b1 || q !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_sticky: ack=%b fault=%b q=%b, required ack=0010 fault=1 q=0", a, fault, q);
        end
        @(posedge clk); #1;
        clr_req = '0;
        do_reset();
        n_checks++;
        if (fault !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_clear: fault=%b, required 0", fault);
        end
    endtask

    task automatic test_reset_mid();
        int n_r;
        logic ss, sa;
        set_req = 4'b1000;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (latch_set !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pulse1: latch_set=%b, required 1", latch_set);
        end
        @(negedge clk);
        rst_n = 1'b0; set_req = '0;
        #1;
        n_checks++;
        if (latch_set !== 1'b0 || ack !== 4'b0 || busy !== 1'b0 || mq !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_abort: set=%b ack=%b busy=%b q=%b, required set=0 ack=0 busy=0 q=1",
                     latch_set, ack, busy, mq);
        end
        @(negedge clk);
        rst_n = 1'b1;
        n_r = 0; ss = 1'b0; sa = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (latch_reset) n_r++;
            ss = ss | latch_set;
            sa = sa | (ack != 4'b0);
        end
        n_checks++;
        if (n_r != 2 || ss !== 1'b0 || sa !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rerun: reset_cycles=%0d saw_set=%b saw_ack=%b, required 2 0 0", n_r, ss, sa);
        end
        n_checks++;
        if (q !== 1'b0 || busy !== 1'b0 || fault !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_final: q=%b busy=%b fault=%b, required 0 0 0", q, busy, fault);
        end
    endtask

    initial begin
        test_reset();
        test_single_set();
        test_round_robin();
        test_clear_priority();
        test_fault();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
